ofdm_cp_remove: RTL and testbench

Receive-side cyclic-prefix remover for the 64-point OFDM chain. It sits between the sample source and `FFT64`. It strips the `CP_LEN`-sample prefix from each received symbol and stores the `N` useful samples in a ping-pong buffer. It then presents each symbol to the FFT as one gap-free burst of `N` samples on `out_en`. It is the counterpart of the transmit-side prefix inserter that follows `IFFT64`.

---
 rtl/ofdm_pkg.sv | 19 +
 rtl/ofdm_pingpong_ram.sv | 47 ++++
 rtl/ofdm_cp_remove.sv | 188 ++++++++++++++++++
 tb/tb_ofdm_cp_remove.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared defaults and FSM encodings for the OFDM receive chain
package ofdm_pkg;

  localparam int N_FFT      = 64;
  localparam int CP_LEN_DEF = 16;
  localparam int SAMPLE_W   = 16;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SKIP = 2'd1,
    FILL = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// rtl/ofdm_pingpong_ram.sv - two-bank sample buffer, one write port, one registered read port
// Bank select is the address MSB; the storage array itself is not reset.
module ofdm_pingpong_ram
  import ofdm_pkg::*;
#(
  parameter int N  = N_FFT,
  parameter int W  = SAMPLE_W,
  localparam int AW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW:0]    wr_addr,
  input  logic [2*W-1:0] wr_data,
  input  logic           rd_en,
  input  logic [AW:0]    rd_addr,
  output logic [2*W-1:0] rd_data
);

  logic [2*W-1:0] mem_q [0:2*N-1];
  logic [2*W-1:0] rd_data_d;
  logic [2*W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ofdm_cp_remove.sv
// rtl/ofdm_cp_remove.sv - strips the cyclic prefix and replays each symbol as one gap-free burst
// Writer frames symbols on in_sof only; reader drains full banks in ping-pong order.
module ofdm_cp_remove
  import ofdm_pkg::*;
#(
  parameter int N      = N_FFT,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int W      = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_en,
  output logic         out_sof,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         sync_err
);

  localparam int              AW        = $clog2(N);
  localparam logic [AW-1:0]   CP_LAST   = AW'(CP_LEN - 1);
  localparam logic [AW-1:0]   N_LAST    = AW'(N - 1);
  localparam logic [AW-1:0]   CNT_ONE   = AW'(1);
  // With a one-sample prefix the sof sample is the whole prefix, so filling starts next.
  localparam wr_state_t       SOF_STATE = (CP_LEN == 1) ? FILL : SKIP;
  localparam logic [AW-1:0]   SOF_CNT   = (CP_LEN == 1) ? '0 : CNT_ONE;

  wr_state_t     wstate_q, wstate_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          wsel_q, wsel_d;
  logic          wr_done;
  logic          sync_err_q, sync_err_d;

  rd_state_t     rstate_q, rstate_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic          rsel_q, rsel_d;
  logic          rd_done;

  logic [1:0]    full_q, full_d;
  logic          out_en_q, out_en_d;
  logic          out_sof_q, out_sof_d;

  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic          rd_en;
  logic [AW:0]   rd_addr;
  logic [2*W-1:0] rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q   <= HUNT;
      wcnt_q     <= '0;
      wsel_q     <= 1'b0;
      sync_err_q <= 1'b0;
      rstate_q   <= R_IDLE;
      rcnt_q     <= '0;
      rsel_q     <= 1'b0;
      full_q     <= 2'b00;
      out_en_q   <= 1'b0;
      out_sof_q  <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      wcnt_q     <= wcnt_d;
      wsel_q     <= wsel_d;
      sync_err_q <= sync_err_d;
      rstate_q   <= rstate_d;
      rcnt_q     <= rcnt_d;
      rsel_q     <= rsel_d;
      full_q     <= full_d;
      out_en_q   <= out_en_d;
      out_sof_q  <= out_sof_d;
    end
  end

  always_comb begin
    wstate_d   = wstate_q;
    wcnt_d     = wcnt_q;
    wsel_d     = wsel_q;
    wr_done    = 1'b0;
    sync_err_d = 1'b0;
    if (in_valid) begin
      case (wstate_q)
        HUNT: begin
          if (in_sof) begin
            wstate_d = SOF_STATE;
            wcnt_d   = SOF_CNT;
          end
        end
        SKIP, FILL: begin
          if (in_sof) begin
            // Early sof abandons the partial bank and restarts framing here.
            sync_err_d = 1'b1;
            wstate_d   = SOF_STATE;
            wcnt_d     = SOF_CNT;
          end else if (wstate_q == SKIP) begin
            if (wcnt_q == CP_LAST) begin
              wstate_d = FILL;
              wcnt_d   = '0;
            end else begin
              wcnt_d = wcnt_q + CNT_ONE;
            end
          end else if (wcnt_q == N_LAST) begin
            wr_done  = 1'b1;
            wsel_d   = ~wsel_q;
            wstate_d = HUNT;
            wcnt_d   = '0;
          end else begin
            wcnt_d = wcnt_q + CNT_ONE;
          end
        end
        default: wstate_d = HUNT;
      endcase
    end
  end

  always_comb begin
    wr_en   = in_valid && !in_sof && (wstate_q == FILL);
    wr_addr = {wsel_q, wcnt_q};
  end

  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rsel_d   = rsel_q;
    rd_done  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (full_q[rsel_q]) begin
          rstate_d = R_BURST;
          rcnt_d   = '0;
        end
      end
      R_BURST: begin
        if (rcnt_q == N_LAST) begin
          rd_done  = 1'b1;
          rsel_d   = ~rsel_q;
          rstate_d = R_IDLE;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + CNT_ONE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // A completing write and a finishing read always address different banks.
  always_comb begin
    full_d = full_q;
    if (rd_done) begin
      full_d[rsel_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wsel_q] = 1'b1;
    end
  end

  always_comb begin
    rd_en     = (rstate_q == R_BURST);
    rd_addr   = {rsel_q, rcnt_q};
    out_en_d  = rd_en;
    out_sof_d = rd_en && (rcnt_q == '0);
  end

  ofdm_pingpong_ram #(
    .N (N),
    .W (W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign out_en   = out_en_q;
  assign out_sof  = out_sof_q;
  assign out_re   = rd_data[2*W-1:W];
  assign out_im   = rd_data[W-1:0];
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_ofdm_cp_remove.sv
// tb/tb_ofdm_cp_remove.sv - directed self-checking bench for ofdm_cp_remove
module tb_ofdm_cp_remove;

  localparam int N  = 64;
  localparam int CP = 16;
  localparam int W  = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         out_en;
  logic         out_sof;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         sync_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_in_cyc = 0;
  int serr_cnt = 0;
  int t_last;
  bit found;
  logic [W-1:0] exp_re;

  logic [W-1:0] oq_re[$];
  logic [W-1:0] oq_im[$];
  logic         oq_sof[$];
  int           oq_cyc[$];

  ofdm_cp_remove #(
    .N      (N),
    .CP_LEN (CP),
    .W      (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_en   (out_en),
    .out_sof  (out_sof),
    .out_re   (out_re),
    .out_im   (out_im),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_en) begin
      oq_re.push_back(out_re);
      oq_im.push_back(out_im);
      oq_sof.push_back(out_sof);
      oq_cyc.push_back(cyc);
    end
    if (sync_err) serr_cnt++;
    if (in_valid) last_in_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    oq_re.delete();
    oq_im.delete();
    oq_sof.delete();
    oq_cyc.delete();
    serr_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic sof, input int val);
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = W'(val);
    in_im    = W'(-val);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_symbol(input int base, input bit gapped);
    for (int k = 0; k < N + CP; k++) begin
      send(k == 0, base + k);
      if (gapped) idle(1);
    end
  endtask

  task automatic verify_burst(input string tag, input int idx, input int base);
    logic [W-1:0] er;
    logic [W-1:0] ei;
    if (oq_re.size() >= idx + N) begin
      for (int i = 0; i < N; i++) begin
        er = W'(base + CP + i);
        ei = W'(-(base + CP + i));
        check_eq({tag, " re"}, oq_re[idx+i], er);
        check_eq({tag, " im"}, oq_im[idx+i], ei);
        check_eq({tag, " sof"}, oq_sof[idx+i], (i == 0) ? 1 : 0);
        check_eq({tag, " contiguous"}, oq_cyc[idx+i], oq_cyc[idx] + i);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    reset    = 1'b1;
    idle(3);
    check_eq("reset out_en", out_en, 0);
    check_eq("reset out_sof", out_sof, 0);
    check_eq("reset out_re", out_re, 0);
    check_eq("reset out_im", out_im, 0);
    check_eq("reset sync_err", sync_err, 0);
    reset = 1'b0;
    idle(2);

    clear_mon();
    send_symbol(0, 1'b0);
    t_last = last_in_cyc;
    idle(80);
    check_eq("single count", oq_re.size(), N);
    if (oq_cyc.size() > 0) check_eq("single latency", oq_cyc[0] - t_last, 3);
    verify_burst("single", 0, 0);
    check_eq("single sync_err", serr_cnt, 0);

    clear_mon();
    send_symbol(0, 1'b1);
    t_last = last_in_cyc;
    idle(80);
    check_eq("gapped count", oq_re.size(), N);
    if (oq_cyc.size() > 0) check_eq("gapped latency", oq_cyc[0] - t_last, 3);
    verify_burst("gapped", 0, 0);

    clear_mon();
    send_symbol(100, 1'b0);
    send_symbol(200, 1'b0);
    send_symbol(300, 1'b0);
    idle(80);
    check_eq("b2b count", oq_re.size(), 3 * N);
    verify_burst("b2b sym0", 0, 100);
    verify_burst("b2b sym1", N, 200);
    verify_burst("b2b sym2", 2 * N, 300);
    if (oq_cyc.size() == 3 * N) begin
      check_eq("b2b gap01", oq_cyc[N] - oq_cyc[N-1], CP + 1);
      check_eq("b2b gap12", oq_cyc[2*N] - oq_cyc[2*N-1], CP + 1);
    end
    check_eq("b2b sync_err", serr_cnt, 0);

    clear_mon();
    for (int k = 0; k < 50; k++) send(k == 0, 500 + k);
    send_symbol(600, 1'b0);
    idle(80);
    check_eq("early sync_err pulses", serr_cnt, 1);
    check_eq("early count", oq_re.size(), N);
    verify_burst("early symB", 0, 600);

    clear_mon();
    for (int k = 0; k < 37; k++) send(1'b0, 900 + k);
    send_symbol(1000, 1'b0);
    idle(80);
    check_eq("garbage count", oq_re.size(), N);
    verify_burst("garbage sym", 0, 1000);
    check_eq("garbage sync_err", serr_cnt, 0);

    clear_mon();
    send_symbol(1200, 1'b0);
    found  = 1'b0;
    exp_re = W'(1200 + CP + 20);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_en && out_re == exp_re) found = 1'b1;
    end
    check_eq("midreset reached sample 20", found, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("midreset out_en", out_en, 0);
    check_eq("midreset out_sof", out_sof, 0);
    check_eq("midreset out_re", out_re, 0);
    check_eq("midreset out_im", out_im, 0);
    check_eq("midreset sync_err", sync_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_mon();
    idle(150);
    check_eq("midreset no burst", oq_re.size(), 0);
    send_symbol(1300, 1'b0);
    idle(80);
    check_eq("after reset count", oq_re.size(), N);
    verify_burst("after reset", 0, 1300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
